search_tile: RTL and testbench

SEARCH_TILE -- requirements
Module: search_tile

---
 rtl/search_tile.sv | 140 ++++++++++++++
 tb/tb_search_tile.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/search_tile.sv
// One backtracking-search cell: walks a persistent one-hot index, asks the bias module for candidates, accepts or backtracks.
// Optional macro TILE_TRYCOUNT_EN enables the saturating candidate-evaluation counter on tries.
module search_tile #(
  parameter int LEN   = 9,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             myturn,
  input  logic             fromback,
  output logic             passfwd,
  output logic             passbak,
  output logic             rq_valtotry,
  input  logic             ack_valtotry,
  output logic [LEN-1:0]   biasidx,
  input  logic [LEN-1:0]   valtotry,
  input  logic [LEN-1:0]   valcannotbe,
  input  logic             given_ld,
  input  logic [LEN-1:0]   given_val,
  output logic             locked,
  output logic [LEN-1:0]   value,
  output logic [CNT_W-1:0] tries
);

  typedef enum logic [2:0] {
    RESET, WAITING, INCRIDX, RQROWBS, LDROWBS, PASSBAK, PASSFWD
  } state_t;

  // MSB of the index is the "empty" position, one step before candidate 0.
  localparam logic [LEN:0] IDX_EMPTY = {1'b1, {LEN{1'b0}}};

  state_t         state_q, state_d;
  logic [LEN:0]   index_q, index_d;
  logic [LEN-1:0] value_q, value_d;
  logic [LEN-1:0] cap_q, cap_d;
  logic           locked_q, locked_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= RESET;
      index_q  <= IDX_EMPTY;
      value_q  <= '0;
      cap_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      value_q  <= value_d;
      cap_q    <= cap_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    value_d     = value_q;
    cap_d       = cap_q;
    locked_d    = locked_q;
    passfwd     = 1'b0;
    passbak     = 1'b0;
    rq_valtotry = 1'b0;
    biasidx     = '0;
    unique case (state_q)
      RESET: state_d = WAITING;
      WAITING: begin
        // A given load takes priority over an arriving turn.
        if (given_ld) begin
          if (|given_val) begin
            value_d  = given_val;
            locked_d = 1'b1;
          end else begin
            value_d  = '0;
            locked_d = 1'b0;
            index_d  = IDX_EMPTY;
          end
        end else if (myturn) begin
          if (locked_q) state_d = fromback ? PASSBAK : PASSFWD;
          else          state_d = INCRIDX;
        end
      end
      INCRIDX: begin
        index_d = {index_q[LEN-1:0], index_q[LEN]};
        if (index_q[LEN-1]) begin
          value_d = '0;
          state_d = PASSBAK;
        end else begin
          state_d = RQROWBS;
        end
      end
      RQROWBS: begin
        rq_valtotry = 1'b1;
        biasidx     = index_q[LEN-1:0];
        if (ack_valtotry) begin
          cap_d   = valtotry;
          state_d = LDROWBS;
        end
      end
      LDROWBS: begin
        if (|(cap_q & valcannotbe)) begin
          state_d = INCRIDX;
        end else begin
          value_d = cap_q;
          state_d = PASSFWD;
        end
      end
      PASSFWD: begin
        passfwd = 1'b1;
        state_d = WAITING;
      end
      PASSBAK: begin
        passbak = 1'b1;
        state_d = WAITING;
      end
      default: state_d = RESET;
    endcase
  end

  assign value  = value_q;
  assign locked = locked_q;

`ifdef TILE_TRYCOUNT_EN
  logic [CNT_W-1:0] tries_q, tries_d;

  always_comb begin
    tries_d = tries_q;
    if (state_q == RQROWBS && ack_valtotry && !(&tries_q)) tries_d = tries_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tries_q <= '0;
    else       tries_q <= tries_d;
  end

  assign tries = tries_q;
`else
  assign tries = '0;
`endif

endmodule

// File: tb/tb_search_tile.sv
// Scoreboard bench for search_tile at LEN=4: a bias responder and an outcome monitor pop expectations queued by the stimulus.
module tb_search_tile;
  localparam int LEN   = 4;
  localparam int CNT_W = 16;
`ifdef TILE_TRYCOUNT_EN
  localparam int EXP_TRIES4 = 4;
`else
  localparam int EXP_TRIES4 = 0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             myturn, fromback;
  logic             passfwd, passbak, rq_valtotry, ack_valtotry;
  logic [LEN-1:0]   biasidx, valtotry, valcannotbe, given_val, value;
  logic             given_ld, locked;
  logic [CNT_W-1:0] tries;

  search_tile #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .myturn(myturn), .fromback(fromback),
    .passfwd(passfwd), .passbak(passbak), .rq_valtotry(rq_valtotry),
    .ack_valtotry(ack_valtotry), .biasidx(biasidx), .valtotry(valtotry),
    .valcannotbe(valcannotbe), .given_ld(given_ld), .given_val(given_val),
    .locked(locked), .value(value), .tries(tries)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [LEN-1:0]   exp_bias[$];
  logic [LEN-1:0]   resp_q[$];
  logic [LEN+1:0]   exp_out[$];
  logic             resp_en;
  logic             late_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bias module model: acks each request one cycle after it is seen.
  initial begin
    logic [LEN-1:0] eb;
    ack_valtotry = 1'b0;
    valtotry     = '0;
    forever begin
      @(negedge clock);
      if (late_ack) begin
        ack_valtotry = 1'b1;
        valtotry     = 4'b0001;
      end else begin
        ack_valtotry = 1'b0;
        valtotry     = '0;
        if (resp_en && rq_valtotry && !reset) begin
          if (exp_bias.size() == 0) begin
            check("unexp_rq", 32'(rq_valtotry), 0);
          end else begin
            @(negedge clock);
            eb = exp_bias.pop_front();
            check("biasidx", 32'(biasidx), 32'(eb));
            check("rq_held", 32'(rq_valtotry), 1);
            valtotry     = (resp_q.size() != 0) ? resp_q.pop_front() : '0;
            ack_valtotry = 1'b1;
            @(negedge clock);
            ack_valtotry = 1'b0;
            valtotry     = '0;
          end
        end
      end
    end
  end

  // Outcome monitor: every pass pulse must match the next queued {passfwd,passbak,value}.
  initial begin
    logic [LEN+1:0] eo;
    forever begin
      @(negedge clock);
      if (!reset && (passfwd || passbak)) begin
        if (exp_out.size() == 0) begin
          check("unexp_pass", 32'({passfwd, passbak}), 0);
        end else begin
          eo = exp_out.pop_front();
          check("outcome", 32'({passfwd, passbak, value}), 32'(eo));
        end
      end
    end
  end

  task automatic take_turn(input logic fb);
    myturn   = 1'b1;
    fromback = fb;
    @(negedge clock);
    myturn   = 1'b0;
    fromback = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_out.size() != 0 || exp_bias.size() != 0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", 32'(exp_out.size() + exp_bias.size()), 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic load_given(input logic [LEN-1:0] v);
    given_ld  = 1'b1;
    given_val = v;
    @(negedge clock);
    given_ld  = 1'b0;
    given_val = '0;
  endtask

  initial begin
    int n;
    reset = 1'b1; myturn = 1'b0; fromback = 1'b0; valcannotbe = '0;
    given_ld = 1'b0; given_val = '0; resp_en = 1'b1; late_ack = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_rq", 32'(rq_valtotry), 0);
    check("rst_value", 32'(value), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("post_rst_locked", 32'(locked), 0);
    check("post_rst_tries", 32'(tries), 0);
    check("post_rst_bias", 32'(biasidx), 0);
    check("post_rst_pass", 32'({passfwd, passbak}), 0);

    // Every candidate excluded: four handshakes then backtrack with empty value.
    valcannotbe = 4'b1111;
    resp_q   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_bias = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_out.push_back({2'b01, 4'b0000});
    take_turn(1'b0);
    wait_idle();
    check("tries_exhaust", 32'(tries), EXP_TRIES4);

    // Straight accept, index restarts at 0001 after exhaustion.
    valcannotbe = '0;
    resp_q.push_back(4'b0010);
    exp_bias.push_back(4'b0001);
    exp_out.push_back({2'b10, 4'b0010});
    take_turn(1'b0);
    wait_idle();
    check("accept_value", 32'(value), 32'(4'b0010));

    // Clearing load empties the tile and rewinds the index.
    load_given(4'b0000);
    check("clr_value", 32'(value), 0);
    check("clr_locked", 32'(locked), 0);

    // First candidate rejected by peers, second accepted.
    valcannotbe = 4'b0010;
    resp_q   = '{4'b0010, 4'b0100};
    exp_bias = '{4'b0001, 4'b0010};
    exp_out.push_back({2'b10, 4'b0100});
    take_turn(1'b0);
    wait_idle();

    // Backtracked turn resumes after the last tried index.
    valcannotbe = '0;
    resp_q.push_back(4'b0001);
    exp_bias.push_back(4'b0100);
    exp_out.push_back({2'b10, 4'b0001});
    take_turn(1'b1);
    wait_idle();
    check("resume_value", 32'(value), 32'(4'b0001));

    // Locked given: pass straight through, no bias request.
    load_given(4'b1000);
    check("given_locked", 32'(locked), 1);
    check("given_value", 32'(value), 32'(4'b1000));
    exp_out.push_back({2'b10, 4'b1000});
    take_turn(1'b0);
    check("locked_fwd_next", 32'(passfwd), 1);
    wait_idle();
    exp_out.push_back({2'b01, 4'b1000});
    take_turn(1'b1);
    check("locked_bak_next", 32'(passbak), 1);
    wait_idle();

    // Load together with myturn: load wins, turn dropped.
    given_ld = 1'b1; given_val = '0; myturn = 1'b1;
    @(negedge clock);
    given_ld = 1'b0; myturn = 1'b0;
    repeat (4) @(negedge clock);
    check("ldturn_locked", 32'(locked), 0);
    check("ldturn_rq", 32'(rq_valtotry), 0);

    // Give the tile a value, then reset while a request is outstanding.
    resp_q.push_back(4'b0001);
    exp_bias.push_back(4'b0001);
    exp_out.push_back({2'b10, 4'b0001});
    take_turn(1'b0);
    wait_idle();
    resp_en = 1'b0;
    take_turn(1'b0);
    n = 0;
    while (!rq_valtotry && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("midrq_seen", 32'(rq_valtotry), 1);
    check("midrq_bias", 32'(biasidx), 32'(4'b0010));
    #2 reset = 1'b1;
    #1;
    check("abort_rq", 32'(rq_valtotry), 0);
    check("abort_bias", 32'(biasidx), 0);
    check("abort_value", 32'(value), 0);
    check("abort_tries", 32'(tries), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1 late_ack = 1'b1;
    repeat (2) @(negedge clock);
    #1 late_ack = 1'b0;
    repeat (4) @(negedge clock);
    check("late_ack_rq", 32'(rq_valtotry), 0);
    check("late_ack_value", 32'(value), 0);
    check("late_ack_outq", 32'(exp_out.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
